// File: rtl/alu_arb.sv
// Round-robin arbiter and sequencer for the shared logic ALU.
// Two requesters take turns. One operation is in flight at a time. The ALU
// inputs come from registers, and the result is held with the owner's ID
// until the owner acknowledges it.
module alu_arb #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Req0,
    input  logic             Req1,
    input  logic [1:0]       Op0,
    input  logic [1:0]       Op1,
    input  logic [W-1:0]     A0,
    input  logic [W-1:0]     B0,
    input  logic [W-1:0]     A1,
    input  logic [W-1:0]     B1,
    output logic             Gnt0,
    output logic             Gnt1,
    output logic [1:0]       Upr_ALU,
    output logic [W-1:0]     A_ALU,
    output logic [W-1:0]     B_ALU,
    input  logic [W-1:0]     Out_ALU,
    output logic             Res_valid,
    output logic [W-1:0]     Res_data,
    output logic             Res_id,
    input  logic             Res_ack,
    output logic             Busy,
    output logic [CNT_W-1:0] Op_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   prio;
    logic   sel;

    assign Busy = (state != IDLE);

    // Grant selection and next-state logic.
    // Grants are only issued in IDLE and are suppressed while reset is asserted.
    always_comb begin
        state_next = state;
        Gnt0       = 1'b0;
        Gnt1       = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (Req0 && (!Req1 || !prio)) begin
                        Gnt0 = 1'b1;
                    end else if (Req1) begin
                        Gnt1 = 1'b1;
                    end
                    if (Gnt0 || Gnt1) begin
                        state_next = EXEC;
                    end
                end
            end
            EXEC: state_next = DONE;
            DONE: begin
                if (Res_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: operand latching, result capture, priority flip and op counting.
    // Reset during EXEC or DONE drops the operation without producing a response or counting it.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio      <= 1'b0;
            sel       <= 1'b0;
            Upr_ALU   <= 2'd0;
            A_ALU     <= '0;
            B_ALU     <= '0;
            Res_valid <= 1'b0;
            Res_data  <= '0;
            Res_id    <= 1'b0;
            Op_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Gnt1) begin
                        Upr_ALU <= Op1;
                        A_ALU   <= A1;
                        B_ALU   <= B1;
                        sel     <= 1'b1;
                    end else if (Gnt0) begin
                        Upr_ALU <= Op0;
                        A_ALU   <= A0;
                        B_ALU   <= B0;
                        sel     <= 1'b0;
                    end
                end
                EXEC: begin
                    Res_data  <= Out_ALU;
                    Res_id    <= sel;
                    Res_valid <= 1'b1;
                end
                DONE: begin
                    if (Res_ack) begin
                        Res_valid <= 1'b0;
                        prio      <= ~Res_id;
                        Op_cnt    <= Op_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arb.sv
// Testbench for alu_arb. A transaction-level model is checked every cycle,
// and literal expectations from directed scenarios are checked as well.
module tb_alu_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        Req0, Req1;
    logic [1:0]  Op0, Op1;
    logic [31:0] A0, B0, A1, B1;
    logic        Gnt0, Gnt1;
    logic [1:0]  Upr_ALU;
    logic [31:0] A_ALU, B_ALU, Out_ALU;
    logic        Res_valid;
    logic [31:0] Res_data;
    logic        Res_id;
    logic        Res_ack;
    logic        Busy;
    logic [3:0]  Op_cnt;

    int checks   = 0;
    int failures = 0;

    // Behavioural logic ALU: zero, one, OR, AND.
    function automatic logic [31:0] alu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return 32'h0;
            2'd1:    return 32'h1;
            2'd2:    return a | b;
            default: return a & b;
        endcase
    endfunction

    assign Out_ALU = alu_fn(Upr_ALU, A_ALU, B_ALU);

    alu_arb #(.W(32), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .Req0(Req0), .Req1(Req1), .Op0(Op0), .Op1(Op1),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .Gnt0(Gnt0), .Gnt1(Gnt1),
        .Upr_ALU(Upr_ALU), .A_ALU(A_ALU), .B_ALU(B_ALU), .Out_ALU(Out_ALU),
        .Res_valid(Res_valid), .Res_data(Res_data), .Res_id(Res_id),
        .Res_ack(Res_ack), .Busy(Busy), .Op_cnt(Op_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Raise a request, wait for its grant, then withdraw the request after the grant edge.
    task automatic applyStimulus(input bit who, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit got;
        got = 1'b0;
        if (who) begin
            Req1 = 1'b1; Op1 = op; A1 = a; B1 = b;
        end else begin
            Req0 = 1'b1; Op0 = op; A0 = a; B0 = b;
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if ((who && Gnt1) || (!who && Gnt0)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) checkOutput("grant_timeout", 32'd0, 32'd1);
        nextCycle();
        if (who) Req1 = 1'b0; else Req0 = 1'b0;
    endtask

    // Transaction-level model state.
    int          m_phase;   // 0 waiting for work, 1 operation issued, 2 response pending
    logic        m_prio, m_sel, m_valid, m_id;
    logic [1:0]  m_upr;
    logic [31:0] m_a, m_b, m_res, m_data;
    logic [3:0]  m_cnt;

    // Compare process: check all outputs on every falling edge, then advance the model
    // using the inputs that the next rising edge will sample.
    initial begin : compare
        logic eg0, eg1;
        m_phase = 0; m_prio = 0; m_sel = 0; m_valid = 0; m_id = 0;
        m_upr = 0; m_a = 0; m_b = 0; m_res = 0; m_data = 0; m_cnt = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            eg0 = 1'b0; eg1 = 1'b0;
            if (!rst && m_phase == 0) begin
                if (Req0 && !Req1)      eg0 = 1'b1;
                else if (Req1 && !Req0) eg1 = 1'b1;
                else if (Req0 && Req1) begin
                    eg0 = !m_prio;
                    eg1 = m_prio;
                end
            end
            checkOutput("gnt0", Gnt0, eg0);
            checkOutput("gnt1", Gnt1, eg1);
            checkOutput("busy", Busy, (m_phase != 0));
            checkOutput("res_valid", Res_valid, m_valid);
            checkOutput("res_data", Res_data, m_data);
            checkOutput("res_id", Res_id, m_id);
            checkOutput("op_cnt", Op_cnt, m_cnt);
            checkOutput("upr_alu", Upr_ALU, m_upr);
            checkOutput("a_alu", A_ALU, m_a);
            checkOutput("b_alu", B_ALU, m_b);
            if (rst) begin
                m_phase = 0; m_prio = 0; m_sel = 0; m_valid = 0; m_id = 0;
                m_upr = 0; m_a = 0; m_b = 0; m_data = 0; m_cnt = 0;
            end else if (m_phase == 0) begin
                if (eg0 || eg1) begin
                    m_sel   = eg1;
                    m_upr   = eg1 ? Op1 : Op0;
                    m_a     = eg1 ? A1 : A0;
                    m_b     = eg1 ? B1 : B0;
                    m_res   = alu_fn(m_upr, m_a, m_b);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_valid = 1'b1;
                m_data  = m_res;
                m_id    = m_sel;
                m_phase = 2;
            end else if (Res_ack) begin
                m_valid = 1'b0;
                m_prio  = ~m_id;
                m_cnt   = m_cnt + 4'd1;
                m_phase = 0;
            end
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin : stim
        bit got;
        rst = 1'b1; Req0 = 0; Req1 = 0; Op0 = 0; Op1 = 0;
        A0 = 0; B0 = 0; A1 = 0; B1 = 0; Res_ack = 0;
        nextCycle(); nextCycle();
        rst = 1'b0;

        // Idle after reset.
        repeat (5) nextCycle();
        @(negedge clk);
        checkOutput("idle_gnt", {30'd0, Gnt1, Gnt0}, 32'd0);
        checkOutput("idle_cnt", Op_cnt, 32'd0);
        checkOutput("idle_valid", Res_valid, 32'd0);
        checkOutput("idle_busy", Busy, 32'd0);

        // Single OR operation from requester 0 with ack held high.
        nextCycle();
        Res_ack = 1'b1;
        applyStimulus(1'b0, 2'd2, 32'hF0F0_0000, 32'h0000_0F0F);
        @(negedge clk);
        checkOutput("single_upr", Upr_ALU, 32'd2);
        checkOutput("single_a", A_ALU, 32'hF0F0_0000);
        nextCycle();
        @(negedge clk);
        checkOutput("single_valid", Res_valid, 32'd1);
        checkOutput("single_data", Res_data, 32'hF0F0_0F0F);
        checkOutput("single_id", Res_id, 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("single_cnt", Op_cnt, 32'd1);

        // Both requesters held continuously: grants alternate starting with 0.
        nextCycle();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        Req0 = 1'b1; Op0 = 2'd3; A0 = 32'h1234_5678; B0 = 32'h0F0F_F0F0;
        Req1 = 1'b1; Op1 = 2'd1; A1 = 32'hDEAD_BEEF; B1 = 32'h0BAD_F00D;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int t = 0; t < 10; t++) begin
                @(negedge clk);
                if (Gnt0 || Gnt1) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) checkOutput("rr_timeout", 32'd0, 32'd1);
            checkOutput("rr_grant", Gnt1, k % 2);
            if (k == 3) begin
                nextCycle();
                Req0 = 1'b0; Req1 = 1'b0;
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
            @(negedge clk);
            checkOutput("rr_valid", Res_valid, 32'd1);
            checkOutput("rr_id", Res_id, k % 2);
            checkOutput("rr_data", Res_data, (k % 2) ? 32'h1 : 32'h0204_5070);
        end
        nextCycle();
        @(negedge clk);
        checkOutput("rr_cnt", Op_cnt, 32'd4);

        // Withheld acknowledge: response stays put, no grants while waiting.
        nextCycle();
        Res_ack = 1'b0;
        applyStimulus(1'b0, 2'd2, 32'hAAAA_0000, 32'h0000_5555);
        Req1 = 1'b1; Op1 = 2'd3; A1 = 32'hFFFF_0000; B1 = 32'h00FF_FF00;
        nextCycle();
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            checkOutput("hold_valid", Res_valid, 32'd1);
            checkOutput("hold_data", Res_data, 32'hAAAA_5555);
            checkOutput("hold_busy", Busy, 32'd1);
            checkOutput("hold_gnt1", Gnt1, 32'd0);
            nextCycle();
        end
        Res_ack = 1'b1;
        @(negedge clk);
        nextCycle();
        @(negedge clk);
        checkOutput("release_busy", Busy, 32'd0);
        checkOutput("release_gnt1", Gnt1, 32'd1);
        checkOutput("release_valid", Res_valid, 32'd0);
        nextCycle();
        Req1 = 1'b0;
        nextCycle(); nextCycle();
        @(negedge clk);
        checkOutput("release_result", Res_data, 32'h00FF_0000);

        // Reset during DONE aborts the response and restores priority to requester 0.
        nextCycle();
        applyStimulus(1'b0, 2'd1, 32'h0, 32'h0);
        nextCycle(); nextCycle();
        Res_ack = 1'b0;
        applyStimulus(1'b0, 2'd3, 32'hFFFF_FFFF, 32'h1234_0000);
        nextCycle();
        @(negedge clk);
        checkOutput("abort_pre_valid", Res_valid, 32'd1);
        nextCycle();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_valid", Res_valid, 32'd0);
        checkOutput("abort_cnt", Op_cnt, 32'd0);
        checkOutput("abort_busy", Busy, 32'd0);
        nextCycle();
        Req0 = 1'b1; Op0 = 2'd2; A0 = 32'h0000_00F0; B0 = 32'h0000_000F;
        Req1 = 1'b1; Op1 = 2'd0;
        @(negedge clk);
        checkOutput("abort_regrant0", Gnt0, 32'd1);
        checkOutput("abort_regrant1", Gnt1, 32'd0);
        nextCycle();
        Req0 = 1'b0; Req1 = 1'b0; Res_ack = 1'b1;
        nextCycle(); nextCycle();
        @(negedge clk);
        checkOutput("abort_newcnt", Op_cnt, 32'd1);
        checkOutput("abort_newdata", Res_data, 32'h0000_00FF);

        // Sixteen operations wrap the 4-bit counter back to zero.
        nextCycle();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 2'(i % 4), 32'h1000_0000 + 32'(i), 32'h0000_00FF - 32'(i));
            nextCycle(); nextCycle();
            if (i == 14) begin
                @(negedge clk);
                checkOutput("wrap_cnt15", Op_cnt, 32'd15);
                nextCycle();
            end
        end
        @(negedge clk);
        checkOutput("wrap_cnt0", Op_cnt, 32'd0);

        nextCycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
